logic_sweep_checker: RTL and testbench

LOGIC_SWEEP_CHECKER -- requirements
Module: logic_sweep_checker

---
 rtl/logic_sweep_pkg.sv | 25 ++
 rtl/logic_sweep_checker_golden_f.sv | 19 +
 rtl/logic_sweep_checker.sv | 138 +++++++++++++
 tb/tb_logic_sweep_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_sweep_pkg
// Brief    : Shared widths, vector count and FSM encoding for the
//            exhaustive 3-input logic sweep checker.
// Revision : 1.0
// ============================================================================
package logic_sweep_pkg;

  localparam int VEC_W       = 3;
  localparam int NUM_VECTORS = 8;
  localparam int CNT_W       = 4;

  // Last stimulus vector of a sweep; the sweep never wraps past it.
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/logic_sweep_checker_golden_f.sv
`default_nettype none
// ============================================================================
// Module   : golden_f
// Brief    : Reference function f = (~A & D) | (~A & C) | (C & D).
//            Only instantiated when LOGIC_SWEEP_GOLDEN_EN is defined.
// Revision : 1.0
// ============================================================================
module golden_f (
  input  logic a,
  input  logic c,
  input  logic d,
  output logic f
);

  // Pure combinational reference, evaluated on the registered stimulus.
  assign f = (~a & d) | (~a & c) | (c & d);

endmodule
`default_nettype wire

// File: rtl/logic_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : logic_sweep_checker
// Brief    : Drives all 8 combinations of (A,C,D), waits SETTLE_CYCLES per
//            vector, then compares two implementations' responses. Reports
//            the number of failing vectors and the lowest failing vector.
// Config   : LOGIC_SWEEP_GOLDEN_EN - also fail a vector when f1_in differs
//            from the built-in golden function.
// Revision : 1.0
// ============================================================================
module logic_sweep_checker
  import logic_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             f1_in,
  input  logic             f2_in,
  output logic             a_out,
  output logic             c_out,
  output logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);

  // Reject out-of-range settle lengths at elaboration time.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_param_check
      $error("SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  state_t           r_state;
  logic [VEC_W-1:0] r_vec;
  logic [3:0]       r_settle_cnt;
  logic [CNT_W-1:0] r_mismatch_count;
  logic [VEC_W-1:0] r_first_fail_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             w_fail;

`ifdef LOGIC_SWEEP_GOLDEN_EN
  logic w_golden;

  golden_f u_golden_f (
    .a (r_vec[2]),
    .c (r_vec[1]),
    .d (r_vec[0]),
    .f (w_golden)
  );

  // A vector fails if the implementations disagree or f1 misses the reference.
  assign w_fail = (f1_in != f2_in) || (f1_in != w_golden);
`else
  // A vector fails only if the two implementations disagree.
  assign w_fail = (f1_in != f2_in);
`endif

  // Sweep sequencer: settle, sample, advance; DONE spends its first cycle
  // publishing done/pass, after which a start launches a fresh sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_vec            <= '0;
      r_settle_cnt     <= '0;
      r_mismatch_count <= '0;
      r_first_fail_vec <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (r_state == DONE && !r_done) begin
            r_done <= 1'b1;
            r_pass <= (r_mismatch_count == '0);
          end else if (start) begin
            r_vec            <= '0;
            r_mismatch_count <= '0;
            r_first_fail_vec <= '0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_busy           <= 1'b1;
            r_settle_cnt     <= c_SETTLE_LOAD;
            r_state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_settle_cnt <= 4'd1) begin
            r_settle_cnt <= '0;
            r_state      <= SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          if (w_fail) begin
            r_mismatch_count <= r_mismatch_count + 1'b1;
            if (r_mismatch_count == '0) begin
              r_first_fail_vec <= r_vec;
            end
          end
          if (r_vec == LAST_VEC) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_vec        <= r_vec + 1'b1;
            r_settle_cnt <= c_SETTLE_LOAD;
            r_state      <= SETTLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out          = r_vec[2];
  assign c_out          = r_vec[1];
  assign d_out          = r_vec[0];
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign mismatch_count = r_mismatch_count;
  assign first_fail_vec = r_first_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_logic_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_sweep_checker
// Brief    : Directed bench for logic_sweep_checker. Two instances
//            (SETTLE_CYCLES = 1 and 3) share clock and reset; sel picks which
//            one the stimulus tasks drive and observe. Expected values are
//            hand-computed from f = ~A&D | ~A&C | C&D.
// Config   : LOGIC_SWEEP_GOLDEN_EN changes the expectation of the f=d case.
// Revision : 1.0
// ============================================================================
module tb_logic_sweep_checker;
  import logic_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;          // 0: SETTLE_CYCLES=1 instance, 1: SETTLE_CYCLES=3
  int   mode = 0;            // 0: both correct, 1: f2 tied 0, 2: f1=f2=d

  int n_checks = 0;
  int n_errors = 0;

  logic       a1, c1, d1, busy1, done1, pass1;
  logic [3:0] mc1;
  logic [2:0] ff1;
  logic       a3, c3, d3, busy3, done3, pass3;
  logic [3:0] mc3;
  logic [2:0] ff3;
  logic       start1, start3;
  logic       f1_1, f2_1, f1_3, f2_3;

  always #5 clk = ~clk;

  function automatic logic ref_f(input logic a, input logic c, input logic d);
    return (~a & d) | (~a & c) | (c & d);
  endfunction

  function automatic logic resp1(input int m, input logic a, input logic c, input logic d);
    return (m == 2) ? d : ref_f(a, c, d);
  endfunction

  function automatic logic resp2(input int m, input logic a, input logic c, input logic d);
    if (m == 1) return 1'b0;
    return (m == 2) ? d : ref_f(a, c, d);
  endfunction

  assign start1 = start & ~sel;
  assign start3 = start & sel;
  assign f1_1   = resp1(mode, a1, c1, d1);
  assign f2_1   = resp2(mode, a1, c1, d1);
  assign f1_3   = resp1(mode, a3, c3, d3);
  assign f2_3   = resp2(mode, a3, c3, d3);

  logic [2:0] vec;
  logic       busy, done, pass;
  logic [3:0] mc;
  logic [2:0] ff;
  assign vec  = sel ? {a3, c3, d3} : {a1, c1, d1};
  assign busy = sel ? busy3 : busy1;
  assign done = sel ? done3 : done1;
  assign pass = sel ? pass3 : pass1;
  assign mc   = sel ? mc3 : mc1;
  assign ff   = sel ? ff3 : ff1;

  logic_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f1_in(f1_1), .f2_in(f2_1),
    .a_out(a1), .c_out(c1), .d_out(d1), .busy(busy1), .done(done1),
    .pass(pass1), .mismatch_count(mc1), .first_fail_vec(ff1)
  );

  logic_sweep_checker #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f1_in(f1_3), .f2_in(f2_3),
    .a_out(a3), .c_out(c3), .d_out(d3), .busy(busy3), .done(done3),
    .pass(pass3), .mismatch_count(mc3), .first_fail_vec(ff3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, then follow the sweep until done rises. lat counts edges
  // after the start-sampling edge; hold_ok counts vectors held exp_hold
  // cycles; order_ok is 0 if the vector ever went backwards.
  task automatic run_sweep(input int poke, input int exp_hold,
                           output int lat, output int hold_ok, output int order_ok);
    int hist[8];
    int last;
    foreach (hist[i]) hist[i] = 0;
    lat = -1; order_ok = 1; last = 0; hold_ok = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) hist[vec]++;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      start = (n == poke);
      if (busy) begin
        if (int'(vec) < last) order_ok = 0;
        last = int'(vec);
        hist[vec]++;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    foreach (hist[i]) if (hist[i] == exp_hold) hold_ok++;
  endtask

  int lat, hold_ok, order_ok, n2, ok;
  int exp_mc2, exp_ff2, exp_pass2;

  initial begin
`ifdef LOGIC_SWEEP_GOLDEN_EN
    exp_mc2 = 2; exp_ff2 = 2; exp_pass2 = 0;
`else
    exp_mc2 = 0; exp_ff2 = 0; exp_pass2 = 1;
`endif
    // Reset state
    #12;
    check("rst_busy", int'(busy1 | busy3), 0);
    check("rst_done", int'(done1 | done3), 0);
    check("rst_vec",  int'({a1, c1, d1, a3, c3, d3}), 0);
    check("rst_mc",   int'(mc1) + int'(mc3), 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Both implementations correct, SETTLE_CYCLES=1
    sel = 1'b0; mode = 0;
    run_sweep(0, 2, lat, hold_ok, order_ok);
    check("s1_latency", lat, 17);
    check("s1_holds",   hold_ok, 8);
    check("s1_order",   order_ok, 1);
    check("s1_pass",    int'(pass), 1);
    check("s1_mc",      int'(mc), 0);
    check("s1_ff",      int'(ff), 0);
    check("s1_busy",    int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("s1_done_held", int'(done), 1);
    check("s1_pass_held", int'(pass), 1);

    // f2 tied 0: vectors 1,2,3,7 fail
    mode = 1;
    run_sweep(0, 2, lat, hold_ok, order_ok);
    check("f2z_latency", lat, 17);
    check("f2z_mc",      int'(mc), 4);
    check("f2z_ff",      int'(ff), 1);
    check("f2z_pass",    int'(pass), 0);

    // f1 = f2 = d: only the golden check can see vectors 2 and 5
    mode = 2;
    run_sweep(0, 2, lat, hold_ok, order_ok);
    check("fd_mc",   int'(mc), exp_mc2);
    check("fd_ff",   int'(ff), exp_ff2);
    check("fd_pass", int'(pass), exp_pass2);

    // SETTLE_CYCLES=3 with a start pulse in the middle of the sweep
    sel = 1'b1; mode = 1;
    run_sweep(10, 4, lat, hold_ok, order_ok);
    check("s3_latency", lat, 33);
    check("s3_holds",   hold_ok, 8);
    check("s3_order",   order_ok, 1);
    check("s3_mc",      int'(mc), 4);
    check("s3_ff",      int'(ff), 1);
    check("s3_pass",    int'(pass), 0);

    // Reset while vec=4, f2 tied 0
    sel = 1'b0; mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (busy && vec == 3'd4) begin
        ok = 1;
        break;
      end
    end
    check("mid_reached_vec4", ok, 1);
    check("mid_partial_mc",   int'(mc), 3);
    rst = 1'b1;
    #1;
    check("mid_rst_vec",   int'(vec), 0);
    check("mid_rst_flags", int'({busy, done, pass}), 0);
    check("mid_rst_mc",    int'(mc), 0);
    check("mid_rst_ff",    int'(ff), 0);
    check("mid_rst_state", int'(dut1.r_state), int'(IDLE));
    check("mid_rst_cnt",   int'(dut1.r_settle_cnt), 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    run_sweep(0, 2, lat, hold_ok, order_ok);
    check("post_rst_latency", lat, 17);
    check("post_rst_holds",   hold_ok, 8);
    check("post_rst_mc",      int'(mc), 4);
    check("post_rst_ff",      int'(ff), 1);

    // start held high across DONE: back-to-back sweeps
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check("b2b_first_latency", lat, 17);
    check("b2b_first_mc",      int'(mc), 4);
    @(posedge clk); #1;
    check("b2b_done_drop", int'(done), 0);
    check("b2b_busy",      int'(busy), 1);
    check("b2b_mc_clear",  int'(mc), 0);
    check("b2b_vec0",      int'(vec), 0);
    n2 = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin
        n2 = n;
        break;
      end
    end
    start = 1'b0;
    check("b2b_second_latency", n2, 17);
    check("b2b_second_mc",      int'(mc), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
